wdma_mwr_engine: RTL and testbench
==================================

WDMA_MWR_ENGINE -- requirements
Module: wdma_mwr_engine

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-002 The block SHALL expose `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL expose `wdma_rst_i`, input, 1 bit: soft restart from the DMA FSM.
REQ-004 The block SHALL expose `wdma_start_i`, input, 1 bit: one-cycle pulse that starts a burst.
REQ-005 The block SHALL expose `wdma_addr_i`, input, 40 bits: byte address of the burst; bits [1:0] are ignored.
REQ-006 The block SHALL expose `mwr_len_i`, input, 10 bits: TLP payload length in DW; bit0 is forced to 0; the value 0 means 1024.
REQ-007 The block SHALL expose `mwr_count_i`, input, 16 bits: number of TLPs per burst.
REQ-008 The block SHALL expose `req_id_i`, input, 16 bits: completer/requester ID placed in header DW1.
REQ-009 The block SHALL expose `fifo_dout_i`, input, 64 bits: data word; [63:32] is sent first.
REQ-010 The block SHALL expose `fifo_count_i`, input, 11 bits: occupancy of the sniffer FIFO in 64-bit words.
REQ-011 The block SHALL expose `fifo_rd_o`, output, 1 bit: FIFO read strobe; data is valid on the cycle after the strobe.
REQ-012 The block SHALL expose `tx_data_o`, output, 64 bits: TLP beat; [63:32] is the earlier DW.
REQ-013 The block SHALL expose `tx_sof_o`, `tx_eof_o` and `tx_valid_o`, outputs, 1 bit each: start-of-frame, end-of-frame and beat-valid.
REQ-014 The block SHALL expose `tx_rem_o`, output, 1 bit: 1 means both DWs are valid; 0 means only [63:32] is valid (meaningful on EOF).
REQ-015 The block SHALL expose `tx_ready_i`, input, 1 bit: a beat transfers when `tx_valid_o` and `tx_ready_i` are both high.
REQ-016 The block SHALL expose `wdma_done_o`, output, 1 bit: burst complete; held high until soft restart.
REQ-017 The block SHALL expose `wdma_busy_o`, output, 1 bit: high in every state except IDLE and DONE.
REQ-018 The block SHALL expose `tlp_cnt_o`, output, 16 bits: number of TLPs fully sent in the current burst.

Function
REQ-019 The state machine SHALL have the states IDLE, WAIT, HDR0, HDR1, DATA and DONE.
REQ-020 In IDLE, a `wdma_start_i` pulse SHALL latch address, length, count and request ID; the next state is WAIT, or DONE when `mwr_count_i` is 0.
REQ-021 In WAIT, the block SHALL move to HDR0 only when `fifo_count_i` is at least L/2, so a TLP never stalls for data once SOF has been sent.
REQ-022 HDR0 SHALL send beat {DW0, DW1} with `tx_sof_o` high.
- DW0 = fmt 2'b10 for a 3DW header or 2'b11 for a 4DW header, type 0, TC/TD/EP/attr 0, length = L.
- DW1 = {req_id, tag 8'h00, lastBE 4'hF, firstBE 4'hF}.
REQ-023 For a 3DW header, HDR1 SHALL send {addr[31:2],2'b00 ; D0}; DATA SHALL then send realigned pairs using a one-DW holdover register; the last beat SHALL carry 1 DW with `tx_rem_o` = 0; a TLP is L/2+2 beats.
REQ-024 For a 4DW header, HDR1 SHALL send {24'h0,addr[39:32] ; addr[31:0]}; DATA SHALL send L/2 full beats, the last with `tx_rem_o` = 1; a TLP is L/2+2 beats.
REQ-025 When `tx_ready_i` is low, the block SHALL hold the data, SOF, EOF, valid and REM outputs stable and SHALL NOT read the FIFO.
REQ-026 On EOF transfer, the block SHALL:
- add L*4 to the address with 40-bit wrap-around;
- increment `tlp_cnt_o`;
- go to DONE if this was the last TLP, otherwise to WAIT.
REQ-027 DONE SHALL assert `wdma_done_o` and stay in DONE until `wdma_rst_i`, then go to IDLE.
REQ-028 `wdma_start_i` SHALL be ignored outside IDLE.
REQ-029 `wdma_rst_i` in IDLE or WAIT SHALL go to IDLE at once.
REQ-030 `wdma_rst_i` in HDR0, HDR1 or DATA SHALL let the current TLP complete through EOF, then go to IDLE without asserting done.
REQ-031 `wdma_rst_i` SHALL clear `tlp_cnt_o`.
REQ-032 The block SHALL NOT deassert `tx_valid_o` between SOF and EOF.

Reset
REQ-033 On `rst`, the block SHALL:
- enter IDLE;
- drive all outputs to 0;
- clear the address, counters and holdover registers.
REQ-034 `rst` SHALL override `wdma_rst_i` and `wdma_start_i` in the same cycle.

Configuration
REQ-035 With `WDMA_ADDR64_EN` defined, the block SHALL use a 4DW header when addr[39:32] is non-zero and a 3DW header otherwise; the choice is made per TLP, so a burst that crosses 4 GB switches format.
REQ-036 Without `WDMA_ADDR64_EN`, the block SHALL ignore addr[39:32] and always use a 3DW header.

Structure
REQ-037 A shared package `wdma_pkg` SHALL hold:
- the state enum;
- the fmt/type constants (FMT_MWR32, FMT_MWR64, TYPE_MWR);
- the BE constant;
- the DW0/DW1 field widths.
REQ-038 Header assembly SHALL be one sub-module, `wdma_tlp_hdr`, combinational: inputs are address, length, request ID and the 64-bit select; outputs are 4 DWs and the fmt flag. The FSM, datapath and counters SHALL stay in `wdma_mwr_engine`.

Verification
REQ-039 Burst test: addr 0x80000000, len 32, count 16, FIFO count 1024, ready 1 -> 16 TLPs of 18 beats each, with DW2 = 0x80000000 + n*0x80. EOF beats carry `tx_rem_o` = 0. `wdma_done_o` rises 1 cycle after the 16th EOF and stays high until `wdma_rst_i`.
REQ-040 Stall test: `tx_ready_i` low for 5 cycles mid-DATA -> outputs frozen, no `fifo_rd_o`, and the payload is delivered in order after the stall.
REQ-041 Empty burst: `mwr_count_i` = 0 -> `wdma_done_o` high 1 cycle after start, `tx_valid_o` never asserted.
REQ-042 64-bit address: addr 0x1_0000_0000, len 32, count 1.
- With the macro: fmt 2'b11, DW2 = 0x00000001, DW3 = 0, 18 beats, `tx_rem_o` = 1.
- Without the macro: fmt 2'b10, DW2 = 0.
REQ-043 Soft restart mid-TLP: `wdma_rst_i` during DATA -> the TLP ends with EOF, then IDLE, `wdma_done_o` stays 0, `tlp_cnt_o` = 0.
REQ-044 Low FIFO: `fifo_count_i` = 15 with len 32 -> no SOF; raising the count to 16 -> SOF 1 cycle later.

Source files
------------

// File: rtl/wdma_pkg.sv
// Shared types and TLP field constants for the memory-write DMA engine.
package wdma_pkg;

  // IDLE idle | WAIT wait for payload | HDR0/HDR1 header beats | DATA payload | DONE burst finished
  typedef enum logic [2:0] {IDLE, WAIT, HDR0, HDR1, DATA, DONE} state_e;

  localparam int ADDR_W  = 40;
  localparam int DW_W    = 32;
  localparam int LEN_W   = 10;
  localparam int FMT_W   = 2;
  localparam int TYPE_W  = 5;
  localparam int REQID_W = 16;
  localparam int TAG_W   = 8;
  localparam int BE_W    = 4;

  localparam logic [FMT_W-1:0]  FMT_MWR32 = 2'b10;
  localparam logic [FMT_W-1:0]  FMT_MWR64 = 2'b11;
  localparam logic [TYPE_W-1:0] TYPE_MWR  = 5'b00000;
  localparam logic [BE_W-1:0]   BE_ALL    = 4'hF;

endpackage

// File: rtl/wdma_tlp_hdr.sv
// Combinational MWr header builder: produces DW0..DW3 for a 3DW or 4DW request.
module wdma_tlp_hdr
  import wdma_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [REQID_W-1:0] req_id_i,
  input  logic               sel64_i,
  output logic [DW_W-1:0]    dw0_o,
  output logic [DW_W-1:0]    dw1_o,
  output logic [DW_W-1:0]    dw2_o,
  output logic [DW_W-1:0]    dw3_o,
  output logic               is64_o
);

  logic [FMT_W-1:0] fmt;

  always_comb begin
    fmt    = sel64_i ? FMT_MWR64 : FMT_MWR32;
    // R | fmt | type | R | TC | R | TD | EP | attr | R | length
    dw0_o  = {1'b0, fmt, TYPE_MWR, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len_i};
    dw1_o  = {req_id_i, {TAG_W{1'b0}}, BE_ALL, BE_ALL};
    dw2_o  = sel64_i ? {24'h0, addr_i[39:32]} : {addr_i[31:2], 2'b00};
    dw3_o  = sel64_i ? addr_i[31:0] : '0;
    is64_o = sel64_i;
  end

endmodule

// File: rtl/wdma_mwr_engine.sv
// Memory-write TLP engine: streams FIFO payload as a burst of MWr TLPs.
// Define WDMA_ADDR64_EN to emit 4DW headers for addresses above 4 GB.
module wdma_mwr_engine
  import wdma_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wdma_rst_i,
  input  logic               wdma_start_i,
  input  logic [ADDR_W-1:0]  wdma_addr_i,
  input  logic [LEN_W-1:0]   mwr_len_i,
  input  logic [15:0]        mwr_count_i,
  input  logic [REQID_W-1:0] req_id_i,
  input  logic [63:0]        fifo_dout_i,
  input  logic [10:0]        fifo_count_i,
  output logic               fifo_rd_o,
  output logic [63:0]        tx_data_o,
  output logic               tx_sof_o,
  output logic               tx_eof_o,
  output logic               tx_valid_o,
  output logic               tx_rem_o,
  input  logic               tx_ready_i,
  output logic               wdma_done_o,
  output logic               wdma_busy_o,
  output logic [15:0]        tlp_cnt_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [15:0]         count_q, count_d;
  logic [REQID_W-1:0]  req_id_q, req_id_d;
  logic [15:0]         tlp_cnt_q, tlp_cnt_d;
  logic [DW_W-1:0]     hold_q, hold_d;
  logic [9:0]          beat_q, beat_d;
  logic                abort_q, abort_d;

  logic [9:0]          pairs, pairs_m1;
  logic [ADDR_W-1:0]   addr_inc;
  logic                sel64, is64, last_beat;
  logic [DW_W-1:0]     dw0, dw1, dw2, dw3;

  assign pairs    = (len_q == '0) ? 10'd512 : {1'b0, len_q[9:1]};
  assign pairs_m1 = pairs - 10'd1;
  assign addr_inc = (len_q == '0) ? 40'd4096 : {28'd0, len_q, 2'b00};

`ifdef WDMA_ADDR64_EN
  assign sel64 = |addr_q[39:32];
`else
  assign sel64 = 1'b0;
`endif

  wdma_tlp_hdr u_hdr (
    .addr_i   (addr_q),
    .len_i    (len_q),
    .req_id_i (req_id_q),
    .sel64_i  (sel64),
    .dw0_o    (dw0),
    .dw1_o    (dw1),
    .dw2_o    (dw2),
    .dw3_o    (dw3),
    .is64_o   (is64)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      req_id_q  <= '0;
      tlp_cnt_q <= '0;
      hold_q    <= '0;
      beat_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      req_id_q  <= req_id_d;
      tlp_cnt_q <= tlp_cnt_d;
      hold_q    <= hold_d;
      beat_q    <= beat_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    count_d    = count_q;
    req_id_d   = req_id_q;
    tlp_cnt_d  = tlp_cnt_q;
    hold_d     = hold_q;
    beat_d     = beat_q;
    abort_d    = abort_q;
    tx_valid_o = 1'b0;
    tx_sof_o   = 1'b0;
    tx_eof_o   = 1'b0;
    tx_rem_o   = 1'b0;
    tx_data_o  = '0;
    fifo_rd_o  = 1'b0;
    last_beat  = (beat_q == pairs_m1);

    if (wdma_rst_i) tlp_cnt_d = '0;
    // A soft restart during a TLP is deferred until its EOF has gone out.
    if (wdma_rst_i && (state_q inside {HDR0, HDR1, DATA})) abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wdma_start_i && !wdma_rst_i) begin
          addr_d    = wdma_addr_i & ~40'h3;
          len_d     = mwr_len_i & 10'h3FE;
          count_d   = mwr_count_i;
          req_id_d  = req_id_i;
          tlp_cnt_d = '0;
          state_d   = (mwr_count_i == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (wdma_rst_i) state_d = IDLE;
        else if (fifo_count_i >= {1'b0, pairs}) state_d = HDR0;
      end
      HDR0: begin
        tx_valid_o = 1'b1;
        tx_sof_o   = 1'b1;
        tx_rem_o   = 1'b1;
        tx_data_o  = {dw0, dw1};
        if (tx_ready_i) begin
          fifo_rd_o = !is64;
          state_d   = HDR1;
        end
      end
      HDR1: begin
        tx_valid_o = 1'b1;
        tx_rem_o   = 1'b1;
        tx_data_o  = is64 ? {dw2, dw3} : {dw2, fifo_dout_i[63:32]};
        if (tx_ready_i) begin
          beat_d  = '0;
          state_d = DATA;
          if (is64) begin
            fifo_rd_o = 1'b1;
          end else begin
            hold_d    = fifo_dout_i[31:0];
            fifo_rd_o = (pairs_m1 != '0);
          end
        end
      end
      DATA: begin
        tx_valid_o = 1'b1;
        tx_eof_o   = last_beat;
        tx_rem_o   = !(last_beat && !is64);
        if (is64)           tx_data_o = fifo_dout_i;
        else if (last_beat) tx_data_o = {hold_q, 32'h0};
        else                tx_data_o = {hold_q, fifo_dout_i[63:32]};
        if (tx_ready_i) begin
          if (!last_beat) begin
            beat_d = beat_q + 10'd1;
            if (is64) begin
              fifo_rd_o = 1'b1;
            end else begin
              hold_d    = fifo_dout_i[31:0];
              fifo_rd_o = ((beat_q + 10'd1) < pairs_m1);
            end
          end else begin
            addr_d = addr_q + addr_inc;
            if (abort_q || wdma_rst_i) begin
              tlp_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              tlp_cnt_d = tlp_cnt_q + 16'd1;
              state_d   = ((tlp_cnt_q + 16'd1) == count_q) ? DONE : WAIT;
            end
          end
        end
      end
      DONE: begin
        if (wdma_rst_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wdma_done_o = (state_q == DONE);
  assign wdma_busy_o = (state_q != IDLE) && (state_q != DONE);
  assign tlp_cnt_o   = tlp_cnt_q;

endmodule

// File: tb/tb_wdma_mwr_engine.sv
// Directed self-checking bench for wdma_mwr_engine; honours WDMA_ADDR64_EN like the DUT.
module tb_wdma_mwr_engine;

  logic        clk = 1'b0;
  logic        rst, wdma_rst, start, ready;
  logic [39:0] addr;
  logic [9:0]  len;
  logic [15:0] cnt, rid;
  logic [10:0] fifo_cnt;
  logic [63:0] fifo_dout = '0;
  logic        fifo_rd, tx_sof, tx_eof, tx_valid, tx_rem, done, busy;
  logic [63:0] tx_data;
  logic [15:0] tlp_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] data;
    logic        sof;
    logic        eof;
    logic        rem;
  } beat_t;
  beat_t beats[$];

  int rd_ptr = 0;
  int cyc = 0;
  int valid_seen = 0;
  int xfer_cnt = 0;
  int last_eof_cyc = 0;
  int done_rise_cyc = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  wdma_mwr_engine dut (
    .clk          (clk),
    .rst          (rst),
    .wdma_rst_i   (wdma_rst),
    .wdma_start_i (start),
    .wdma_addr_i  (addr),
    .mwr_len_i    (len),
    .mwr_count_i  (cnt),
    .req_id_i     (rid),
    .fifo_dout_i  (fifo_dout),
    .fifo_count_i (fifo_cnt),
    .fifo_rd_o    (fifo_rd),
    .tx_data_o    (tx_data),
    .tx_sof_o     (tx_sof),
    .tx_eof_o     (tx_eof),
    .tx_valid_o   (tx_valid),
    .tx_rem_o     (tx_rem),
    .tx_ready_i   (ready),
    .wdma_done_o  (done),
    .wdma_busy_o  (busy),
    .tlp_cnt_o    (tlp_cnt)
  );

  function automatic logic [31:0] dwv(input int j);
    return 32'hC000_0000 + 32'(j);
  endfunction

  function automatic logic [63:0] mkword(input int k);
    return {dwv(2*k), dwv(2*k+1)};
  endfunction

  // Expected beat b of a TLP whose first payload DW has global index base.
  function automatic logic [63:0] exp_beat(input bit is64, input logic [39:0] a, input int l,
                                           input int b, input int base, input logic [15:0] r);
    logic [31:0] d0;
    int k;
    d0 = (is64 ? 32'h6000_0000 : 32'h4000_0000) | 32'(l % 1024);
    if (b == 0) return {d0, r, 16'h00FF};
    if (b == 1) return is64 ? {24'h0, a[39:32], a[31:0]} : {a[31:2], 2'b00, dwv(base)};
    k = b - 2;
    return is64 ? {dwv(base+2*k), dwv(base+2*k+1)} : {dwv(base+2*k+1), dwv(base+2*k+2)};
  endfunction

  // FIFO model: data appears the cycle after the strobe and holds until the next one.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      fifo_dout <= mkword(rd_ptr);
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (tx_valid) valid_seen <= valid_seen + 1;
    if (tx_valid && ready) begin
      beats.push_back('{tx_data, tx_sof, tx_eof, tx_rem});
      xfer_cnt <= xfer_cnt + 1;
      if (tx_eof) last_eof_cyc <= cyc;
    end
    if (done && !done_prev) done_rise_cyc <= cyc;
    done_prev <= done;
  end

  task automatic start_burst(input logic [39:0] a, input logic [9:0] l, input logic [15:0] c);
    @(posedge clk); #1;
    addr = a; len = l; cnt = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_wdma_rst();
    @(posedge clk); #1;
    wdma_rst = 1'b1;
    @(posedge clk); #1;
    wdma_rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wdma_rst = 1'b1; start = 1'b1; ready = 1'b1;
    addr = 40'h00_8000_0000; len = 10'd32; cnt = 16'd5; rid = 16'hBEEF; fifo_cnt = 11'd1024;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tx_valid, tx_sof, tx_eof, tx_rem, fifo_rd, done, busy} !== 7'b0 || tx_data !== 64'h0 || tlp_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got ctl=%b data=%h cnt=%0d, want all zero",
               {tx_valid, tx_sof, tx_eof, tx_rem, fifo_rd, done, busy}, tx_data, tlp_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; wdma_rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_over_start: busy=%b want 0", busy); end

    start_burst(40'h0, 10'd8, 16'd2);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx_valid, busy, done, fifo_rd} !== 4'b0 || tlp_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_burst: valid/busy/done/rd=%b cnt=%0d, want 0", {tx_valid, busy, done, fifo_rd}, tlp_cnt);
    end
  endtask

  task automatic test_burst();
    int bi0, base, nb, ntlp, got_n;
    logic [39:0] a;
    a = 40'h00_8000_0000; nb = 18; ntlp = 16;
    @(posedge clk); #1;
    bi0 = beats.size(); base = rd_ptr * 2; ready = 1'b1; fifo_cnt = 11'd1024;
    start_burst(a, 10'd32, 16'd16);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL burst_timeout: done=%b want 1", done); end
    @(posedge clk); #1;
    got_n = beats.size() - bi0;
    n_cmp++;
    if (got_n != ntlp*nb) begin n_err++; $display("FAIL burst_beats: got %0d want %0d", got_n, ntlp*nb); end
    n_cmp++;
    if (done_rise_cyc != last_eof_cyc + 1) begin
      n_err++; $display("FAIL burst_done_latency: rise %0d eof %0d, want eof+1", done_rise_cyc, last_eof_cyc);
    end
    n_cmp++;
    if (rd_ptr*2 - base != ntlp*32) begin n_err++; $display("FAIL burst_fifo_reads: got %0d DW want %0d", rd_ptr*2 - base, ntlp*32); end
    if (got_n >= ntlp*nb) begin
      for (int i = 0; i < ntlp*nb; i++) begin
        int n, b;
        logic [63:0] e, g;
        n = i / nb; b = i % nb;
        e = exp_beat(1'b0, a + 40'(n*128), 32, b, base + n*32, 16'hBEEF);
        g = beats[bi0+i].data;
        if (b == nb-1) begin e[31:0] = '0; g[31:0] = '0; end
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL burst_data tlp %0d beat %0d: got %h want %h", n, b, g, e); end
        n_cmp++;
        if (beats[bi0+i].sof !== (b == 0) || beats[bi0+i].eof !== (b == nb-1)) begin
          n_err++; $display("FAIL burst_framing tlp %0d beat %0d: sof/eof=%b%b", n, b, beats[bi0+i].sof, beats[bi0+i].eof);
        end
        if (b == nb-1) begin
          n_cmp++;
          if (beats[bi0+i].rem !== 1'b0) begin n_err++; $display("FAIL burst_rem tlp %0d: got %b want 0", n, beats[bi0+i].rem); end
        end
      end
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || tlp_cnt !== 16'd16) begin n_err++; $display("FAIL burst_done_hold: done=%b cnt=%0d want 1/16", done, tlp_cnt); end
    pulse_wdma_rst();
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || tlp_cnt !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL burst_restart: done=%b cnt=%0d busy=%b want 0/0/0", done, tlp_cnt, busy);
    end
  endtask

  task automatic test_stall();
    int bi0, base, x0, got_n, frozen_bad;
    logic [63:0] e_frz;
    @(posedge clk); #1;
    bi0 = beats.size(); base = rd_ptr * 2; x0 = xfer_cnt; ready = 1'b1; fifo_cnt = 11'd1024;
    start_burst(40'h1000, 10'd8, 16'd1);
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) begin @(posedge clk); #1; end
    ready = 1'b0;
    e_frz = exp_beat(1'b0, 40'h1000, 8, 3, base, 16'hBEEF);
    frozen_bad = 0;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (tx_data !== e_frz || {tx_valid, tx_sof, tx_eof, fifo_rd} !== 4'b1000) begin
        n_err++; frozen_bad++;
        $display("FAIL stall_frozen: data=%h v/s/e/rd=%b, want %h 1000", tx_data, {tx_valid, tx_sof, tx_eof, fifo_rd}, e_frz);
      end
      @(posedge clk);
    end
    #1 ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    @(posedge clk); #1;
    got_n = beats.size() - bi0;
    n_cmp++;
    if (got_n != 6) begin n_err++; $display("FAIL stall_beats: got %0d want 6", got_n); end
    if (got_n >= 6) begin
      for (int b = 0; b < 6; b++) begin
        logic [63:0] e, g;
        e = exp_beat(1'b0, 40'h1000, 8, b, base, 16'hBEEF);
        g = beats[bi0+b].data;
        if (b == 5) begin e[31:0] = '0; g[31:0] = '0; end
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL stall_data beat %0d: got %h want %h", b, g, e); end
      end
    end
    pulse_wdma_rst();
  endtask

  task automatic test_empty();
    int v0, r0;
    @(posedge clk); #1;
    v0 = valid_seen; r0 = rd_ptr;
    start_burst(40'h4000, 10'd32, 16'd0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL empty_done: done=%b busy=%b want 1/0", done, busy); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (valid_seen != v0 || rd_ptr != r0) begin
      n_err++; $display("FAIL empty_no_tx: valid cycles %0d reads %0d, want 0/0", valid_seen - v0, rd_ptr - r0);
    end
    pulse_wdma_rst();
  endtask

  task automatic test_addr64();
    int bi0, base, got_n;
    bit is64;
    logic [39:0] a;
`ifdef WDMA_ADDR64_EN
    is64 = 1'b1;
`else
    is64 = 1'b0;
`endif
    a = 40'h01_0000_0000;
    @(posedge clk); #1;
    bi0 = beats.size(); base = rd_ptr * 2; ready = 1'b1; fifo_cnt = 11'd1024;
    start_burst(a, 10'd32, 16'd1);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    @(posedge clk); #1;
    got_n = beats.size() - bi0;
    n_cmp++;
    if (got_n != 18) begin n_err++; $display("FAIL a64_beats: got %0d want 18", got_n); end
    if (got_n >= 18) begin
      for (int b = 0; b < 18; b++) begin
        logic [63:0] e, g;
        e = exp_beat(is64, a, 32, b, base, 16'hBEEF);
        g = beats[bi0+b].data;
        if (!is64 && b == 17) begin e[31:0] = '0; g[31:0] = '0; end
        n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL a64_data beat %0d: got %h want %h", b, g, e); end
      end
      n_cmp++;
      if (beats[bi0+17].eof !== 1'b1 || beats[bi0+17].rem !== is64) begin
        n_err++; $display("FAIL a64_eof_rem: eof=%b rem=%b want 1/%b", beats[bi0+17].eof, beats[bi0+17].rem, is64);
      end
    end
    pulse_wdma_rst();
  endtask

  task automatic test_soft_restart();
    int bi0, x0, v0, got_n;
    @(posedge clk); #1;
    bi0 = beats.size(); x0 = xfer_cnt; ready = 1'b1; fifo_cnt = 11'd1024;
    start_burst(40'h2000, 10'd8, 16'd4);
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) begin @(posedge clk); #1; end
    wdma_rst = 1'b1;
    @(posedge clk); #1 wdma_rst = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    @(posedge clk); #1;
    v0 = valid_seen;
    got_n = beats.size() - bi0;
    n_cmp++;
    if (got_n != 6) begin n_err++; $display("FAIL srst_beats: got %0d want 6", got_n); end
    n_cmp++;
    if (got_n < 1 || beats[beats.size()-1].eof !== 1'b1) begin n_err++; $display("FAIL srst_eof: last beat not EOF"); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || tlp_cnt !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL srst_state: done=%b cnt=%0d busy=%b want 0/0/0", done, tlp_cnt, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (valid_seen != v0) begin n_err++; $display("FAIL srst_quiet: %0d valid cycles after restart, want 0", valid_seen - v0); end
  endtask

  task automatic test_low_fifo();
    int bi0, base, v0, got_n;
    @(posedge clk); #1;
    bi0 = beats.size(); base = rd_ptr * 2; ready = 1'b1; fifo_cnt = 11'd15;
    start_burst(40'h3000, 10'd32, 16'd1);
    v0 = valid_seen;
    start_burst(40'hDE_AD00_0000, 10'd8, 16'd0);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (valid_seen != v0 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL lowfifo_hold: valid cycles %0d busy=%b done=%b, want 0/1/0", valid_seen - v0, busy, done);
    end
    fifo_cnt = 11'd16;
    @(negedge clk);
    n_cmp++;
    if (tx_valid !== 1'b0) begin n_err++; $display("FAIL lowfifo_early: valid=%b want 0", tx_valid); end
    @(negedge clk);
    n_cmp++;
    if (tx_sof !== 1'b1 || tx_valid !== 1'b1) begin n_err++; $display("FAIL lowfifo_sof: sof=%b valid=%b want 1/1", tx_sof, tx_valid); end
    fifo_cnt = 11'd1024;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    @(posedge clk); #1;
    got_n = beats.size() - bi0;
    n_cmp++;
    if (got_n < 2 || beats[bi0+1].data !== exp_beat(1'b0, 40'h3000, 32, 1, base, 16'hBEEF)) begin
      n_err++; $display("FAIL lowfifo_addr: beats %0d hdr1=%h want addr 00003000", got_n, (got_n >= 2) ? beats[bi0+1].data : 64'h0);
    end
    pulse_wdma_rst();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_empty();
    test_addr64();
    test_soft_restart();
    test_low_fifo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
